home_force_accumulator: RTL
===========================

// Module: home_force_accumulator
// PURPOSE
//  Downstream of the PE. Consumes the PE's per-pair home force stream (home_frc/_parid/_valid).
//  Sums the forces per home particle ID in an on-chip buffer with an FP32 read-modify-write pipeline.
//  On flush, streams each touched particle's total force in ascending ID order and clears the buffer
//  for the next home cell.
// PARAMETERS
//  PARTICLE_ID_WIDTH  MD_pkg  width of particle ID; buffer depth = 2**PARTICLE_ID_WIDTH entries
//  FADD_LAT           3       latency (cycles) of the instantiated FP32 adder lanes (x, y, z)
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       asynchronous, active-low reset
//  in_frc         in   96      float_data_t {x,y,z} FP32 partial force (from PE home_frc)
//  in_frc_parid   in   PIDW    home particle ID of in_frc
//  in_frc_valid   in   1       in_frc valid
//  in_frc_ready   out  1       input accepted on valid&&ready
//  flush          in   1       1-cycle request: drain and clear buffer
//  flush_done     out  1       1-cycle pulse after last drained entry
//  out_frc        out  96      float_data_t accumulated force
//  out_frc_parid  out  PIDW    particle ID of out_frc
//  out_frc_valid  out  1       out_frc valid
//  out_frc_ready  in   1       downstream accepts on valid&&ready
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all outputs 0
//   - all touched bits cleared
//   - all pipeline valids cleared
//   - state=ACCUM; buffer RAM contents don't care
//  Accumulate pipeline (state ACCUM):
//   - S0 accept: read buffer[parid].
//   - S1: operand = touched ? rdata : +0.0; launch 3 adders (operand + in_frc).
//   - S1+FADD_LAT: write sum back and set touched[parid].
//   - Occupancy window per accepted item = FADD_LAT+1 cycles.
//  Hazard: in_frc_ready=0 when in_frc_parid equals the parid of any valid item in the window.
//   - Different IDs stream at 1/cycle with no stall.
//   - Same ID back-to-back stalls FADD_LAT+1 cycles.
//  Other ready rules:
//   - in_frc_ready=0 in any state other than ACCUM.
//   - parid 0 is reserved: accepted (ready per rules above) but discarded, never written.
//  FP: IEEE-754 single, round-to-nearest-even per adder IP; no NaN/denormal special handling here.
//  FSM:
//   - ACCUM  -> WAIT   on flush (flush ignored in WAIT/DRAIN)
//   - WAIT   -> DRAIN  when pipeline empty
//   - DRAIN  -> ACCUM  after index 2**PIDW-1 is handled; flush_done=1 that same transition cycle
//  DRAIN:
//   - Scan idx 1..2**PIDW-1, one idx/cycle when not stalled.
//   - Untouched idx: skipped, no output.
//   - Touched idx: register {buffer[idx], idx} to out (RAM read latency 1); out_frc_valid=1.
//   - out_frc/out_frc_parid hold stable while valid && !ready.
//   - On handshake: clear touched[idx] and advance.
//  Corner cases:
//   - Nothing touched: flush_done occurs 2**PIDW-1 (+pipeline) cycles after flush with zero outputs.
//   - flush while in_frc_valid: flush wins; the input is not accepted until back in ACCUM.
//   - Reset mid-drain: returns to ACCUM, all touched cleared; no further outputs.
// TESTING
//  1. parid 3, in_frc=(0x3F800000,0x40000000,0xBF800000); flush
//     -> one output parid 3 with the same values, then flush_done.
//  2. parid 5 three times with x=1.0 (0x3F800000); flush
//     -> ready low FADD_LAT+1 cycles between accepts; out x=0x40400000.
//  3. parids 1..15 streamed twice, 1/cycle, x=1.0
//     -> no ready deassertion; flush yields 15 outputs, ids ascending, x=0x40000000.
//  4. test 3 with out_frc_ready toggling 1010...
//     -> outputs change only on handshake, order preserved; flush_done after id 15.
//  5. rst_n pulsed low mid-drain; then flush
//     -> outputs 0 during reset, no outputs after, flush_done only.
//  6. parid 0 input, then flush -> no output; flush also issued during DRAIN -> ignored.

Source files
------------

// File: rtl/home_force_accumulator.sv
// home_force_accumulator
//   Sums the PE's per-pair home forces per particle ID in an on-chip buffer
//   using an FP32 read-modify-write pipeline, then on flush streams every
//   touched entry in ascending ID order and clears it for the next home cell.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_frc[95:0]         {x,y,z} FP32 partial force, with in_frc_parid / in_frc_valid
//   in_frc_ready         input accepted on valid && ready
//   flush                1-cycle drain request (only honoured while accumulating)
//   flush_done           1-cycle pulse once the whole ID range has been drained
//   out_frc[95:0]        {x,y,z} accumulated force, with out_frc_parid / out_frc_valid
//   out_frc_ready        downstream accepts on valid && ready
module home_force_accumulator #(
    parameter int unsigned PARTICLE_ID_WIDTH = 4,
    parameter int unsigned FADD_LAT          = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [95:0]                  in_frc,
    input  logic [PARTICLE_ID_WIDTH-1:0] in_frc_parid,
    input  logic                         in_frc_valid,
    output logic                         in_frc_ready,
    input  logic                         flush,
    output logic                         flush_done,
    output logic [95:0]                  out_frc,
    output logic [PARTICLE_ID_WIDTH-1:0] out_frc_parid,
    output logic                         out_frc_valid,
    input  logic                         out_frc_ready
);

    localparam int unsigned     PIDW     = PARTICLE_ID_WIDTH;
    localparam int unsigned     DEPTH    = 2 ** PIDW;
    localparam int unsigned     FW       = 96;
    localparam logic [PIDW-1:0] FIRST_ID = PIDW'(1);
    localparam logic [PIDW-1:0] LAST_ID  = PIDW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // FP32 add, round-to-nearest-even; zero exponents are treated as zero,
    // overflow saturates to infinity.
    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi;
        logic [31:0] lo;
        logic [26:0] m_hi;
        logic [26:0] m_lo;
        logic [26:0] lo_sh;
        logic [26:0] norm;
        logic [27:0] acc;
        logic [24:0] mant;
        logic [22:0] frac;
        logic [7:0]  d;
        logic        lost;
        logic        rnd;
        logic        found;
        int          e;
        int          lz;
        lost  = 1'b0;
        found = 1'b0;
        lz    = 0;
        if (a[30:0] >= b[30:0]) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end
        if (hi[30:23] == 8'd0) begin
            return {hi[31] & lo[31], 31'd0};
        end
        if (lo[30:23] == 8'd0) begin
            return hi;
        end
        m_hi = {1'b1, hi[22:0], 3'b000};
        m_lo = {1'b1, lo[22:0], 3'b000};
        d    = hi[30:23] - lo[30:23];
        // Align the smaller operand, folding shifted-out bits into sticky.
        if (d > 8'd26) begin
            lo_sh = 27'd1;
        end else begin
            lost  = |(m_lo & ((27'd1 << d) - 27'd1));
            lo_sh = m_lo >> d;
            lo_sh[0] = lo_sh[0] | lost;
        end
        e = int'(hi[30:23]);
        if (hi[31] == lo[31]) begin
            acc = {1'b0, m_hi} + {1'b0, lo_sh};
            if (acc[27]) begin
                norm = {acc[27:2], acc[1] | acc[0]};
                e    = e + 1;
            end else begin
                norm = acc[26:0];
            end
        end else begin
            acc = {1'b0, m_hi} - {1'b0, lo_sh};
            if (acc == 28'd0) begin
                return 32'd0;
            end
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (acc[i]) begin
                        found = 1'b1;
                    end else begin
                        lz = lz + 1;
                    end
                end
            end
            norm = acc[26:0] << lz;
            e    = e - lz;
        end
        rnd  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant = {1'b0, norm[26:3]} + {24'd0, rnd};
        // Rounding carry out of the hidden bit renormalises by one place.
        frac = mant[24] ? mant[23:1] : mant[22:0];
        e    = e + int'(mant[24]);
        if (e >= 255) begin
            return {hi[31], 8'hFF, 23'd0};
        end
        if (e <= 0) begin
            return {hi[31], 31'd0};
        end
        return {hi[31], 8'(e), frac};
    endfunction

    state_t              state_q;
    state_t              state_d;
    logic                live_q;
    logic [PIDW-1:0]     idx_q;
    logic [PIDW-1:0]     idx_d;
    logic [FW-1:0]       mem [DEPTH];
    logic [FW-1:0]       rdata_q;
    logic [PIDW-1:0]     rd_addr;
    logic [DEPTH-1:0]    touched_q;

    logic                s1_valid_q;
    logic [PIDW-1:0]     s1_parid_q;
    logic [FW-1:0]       s1_frc_q;
    logic [FADD_LAT-1:0] st_valid_q;
    logic [PIDW-1:0]     st_parid_q [FADD_LAT];
    logic [FW-1:0]       st_sum_q   [FADD_LAT];

    logic                hazard;
    logic                accept;
    logic                pipe_empty;
    logic                drain_hs;
    logic                drain_load;
    logic                drain_end;
    logic [FW-1:0]       operand;
    logic [FW-1:0]       sum_c;
    logic                wb_valid;
    logic [PIDW-1:0]     wb_parid;
    logic [FW-1:0]       wb_sum;

    assign wb_valid   = st_valid_q[FADD_LAT-1];
    assign wb_parid   = st_parid_q[FADD_LAT-1];
    assign wb_sum     = st_sum_q[FADD_LAT-1];
    assign pipe_empty = !s1_valid_q && (st_valid_q == '0);

    // Same ID already in flight (S1 or any adder stage) must not be re-read yet.
    always_comb begin
        hazard = s1_valid_q && (s1_parid_q == in_frc_parid);
        for (int k = 0; k < int'(FADD_LAT); k++) begin
            if (st_valid_q[k] && (st_parid_q[k] == in_frc_parid)) begin
                hazard = 1'b1;
            end
        end
    end

    assign in_frc_ready = live_q && (state_q == ST_ACCUM) && !flush && !hazard;
    assign accept       = in_frc_valid && in_frc_ready;

    // Untouched entries start from +0.0 regardless of stale RAM contents.
    assign operand = touched_q[s1_parid_q] ? rdata_q : '0;
    assign sum_c   = {fp32_add(operand[95:64], s1_frc_q[95:64]),
                      fp32_add(operand[63:32], s1_frc_q[63:32]),
                      fp32_add(operand[31:0],  s1_frc_q[31:0])};

    // Next-state, drain scan and RAM read address.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_addr    = in_frc_parid;
        drain_hs   = 1'b0;
        drain_load = 1'b0;
        drain_end  = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (flush) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Prefetch the first entry so DRAIN can present it immediately.
                rd_addr = FIRST_ID;
                idx_d   = FIRST_ID;
                if (pipe_empty) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                rd_addr    = idx_q;
                drain_hs   = out_frc_valid && out_frc_ready;
                drain_load = touched_q[idx_q] && !out_frc_valid;
                if (drain_hs || !touched_q[idx_q]) begin
                    if (idx_q == LAST_ID) begin
                        state_d   = ST_ACCUM;
                        drain_end = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        rd_addr = idx_d;
                    end
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // FSM state, scan index and ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            idx_q   <= FIRST_ID;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            live_q  <= 1'b1;
        end
    end

    // Accumulate pipeline: S1 operand capture, then FADD_LAT adder stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_parid_q <= '0;
            s1_frc_q   <= '0;
            st_valid_q <= '0;
            for (int k = 0; k < int'(FADD_LAT); k++) begin
                st_parid_q[k] <= '0;
                st_sum_q[k]   <= '0;
            end
        end else begin
            // ID 0 is reserved: accepted but never enters the pipeline.
            s1_valid_q    <= accept && (in_frc_parid != '0);
            s1_parid_q    <= in_frc_parid;
            s1_frc_q      <= in_frc;
            st_valid_q[0] <= s1_valid_q;
            st_parid_q[0] <= s1_parid_q;
            st_sum_q[0]   <= sum_c;
            for (int k = 1; k < int'(FADD_LAT); k++) begin
                st_valid_q[k] <= st_valid_q[k-1];
                st_parid_q[k] <= st_parid_q[k-1];
                st_sum_q[k]   <= st_sum_q[k-1];
            end
        end
    end

    // Force buffer: one write port (writeback), one registered read port.
    always_ff @(posedge clk) begin
        if (wb_valid) begin
            mem[wb_parid] <= wb_sum;
        end
        rdata_q <= mem[rd_addr];
    end

    // Touched bits: set on writeback, cleared as each entry is handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            touched_q <= '0;
        end else begin
            if (wb_valid) begin
                touched_q[wb_parid] <= 1'b1;
            end
            if (drain_hs) begin
                touched_q[idx_q] <= 1'b0;
            end
        end
    end

    // Output register; payload only reloads when the slot is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_frc       <= '0;
            out_frc_parid <= '0;
            out_frc_valid <= 1'b0;
            flush_done    <= 1'b0;
        end else begin
            flush_done <= drain_end;
            if (drain_load) begin
                out_frc       <= rdata_q;
                out_frc_parid <= idx_q;
                out_frc_valid <= 1'b1;
            end else if (drain_hs) begin
                out_frc_valid <= 1'b0;
            end
        end
    end

endmodule
